// File: rtl/gift_pkg.sv
// Shared GIFT-64 definitions: round-constant width and taps, the PermBits
// index function, the LFSR step and the perm/ark FSM state type.
package gift_pkg;

  localparam int RC_WIDTH = 6;

  // Destination bits of c0..c5 when the round constant is added.
  localparam int GIFT64_RC_TAPS [RC_WIDTH] = '{3, 7, 11, 15, 19, 23};

  typedef enum logic [1:0] {LOAD, APPLY, DRAIN} fsm_t;

  // PermBits: bit i of the input lands on bit p64(i) of the output.
  function automatic int p64(input int i);
    return 4*(i/16) + 16*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
  endfunction

  // One step of the round-constant LFSR.
  function automatic logic [RC_WIDTH-1:0] rc_next(input logic [RC_WIDTH-1:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/gift64_perm_ark_if.sv
// Byte-stream interface of the perm/ark stage.
//   in_*   : S-box output bytes in, plus the round-key halves rk_u/rk_v
//   out_*  : result bytes out
// master = producer/consumer side, slave = the stage itself.
interface gift64_perm_ark_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] rk_u;
  logic [15:0] rk_v;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  modport master (output in_valid, in_data, rk_u, rk_v, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, rk_u, rk_v, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/gift64_permbits.sv
// GIFT-64 PermBits, purely combinational.
//   din  : 64-bit state before permutation
//   dout : 64-bit state after permutation
module gift64_permbits
  import gift_pkg::*;
(
  input  logic [63:0] din,
  output logic [63:0] dout
);
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign dout[p64(i)] = din[i];
  end
endmodule

// File: rtl/gift64_perm_ark.sv
// GIFT-64 round completion stage: collects 8 S-box output bytes, applies
// PermBits + AddRoundKey + round constant in one cycle, then streams the
// 8 result bytes back out. Owns the round-constant LFSR.
//   clk, rst_n  : clock, async active-low reset
//   rc_restart  : reload LFSR and clear round_cnt (new block)
//   bus         : byte in/out handshakes and round-key halves
//   round_cnt   : rounds completed since restart (wraps)
//   busy        : stage holds a partial or complete round
module gift64_perm_ark
  import gift_pkg::*;
#(
  parameter int                  NBYTES  = 8,
  parameter logic [RC_WIDTH-1:0] RC_INIT = 6'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rc_restart,
  gift64_perm_ark_if.slave  bus,
  output logic [4:0]        round_cnt,
  output logic              busy
);
  localparam int CW = $clog2(NBYTES);

  fsm_t                fsm;
  logic [CW-1:0]       cnt;
  logic [63:0]         st_q, perm, applied;
  logic [15:0]         u_q, v_q;
  logic [RC_WIDTH-1:0] lfsr, lfsr_nx;

  gift64_permbits u_perm (.din(st_q), .dout(perm));

  always_comb begin
    lfsr_nx = rc_next(lfsr);
    applied = perm;
    for (int i = 0; i < 16; i++) begin
      applied[4*i+1] = applied[4*i+1] ^ u_q[i];
      applied[4*i]   = applied[4*i]   ^ v_q[i];
    end
    for (int j = 0; j < RC_WIDTH; j++)
      applied[GIFT64_RC_TAPS[j]] = applied[GIFT64_RC_TAPS[j]] ^ lfsr_nx[j];
    applied[63] = ~applied[63];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= LOAD;
      cnt       <= '0;
      st_q      <= '0;
      u_q       <= '0;
      v_q       <= '0;
      lfsr      <= RC_INIT;
      round_cnt <= '0;
    end else begin
      case (fsm)
        LOAD: if (bus.in_valid) begin
          st_q[cnt*8 +: 8] <= bus.in_data;
          if (cnt == CW'(NBYTES-1)) begin
            cnt <= '0;
            u_q <= bus.rk_u;
            v_q <= bus.rk_v;
            fsm <= APPLY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        APPLY: begin
          st_q      <= applied;
          lfsr      <= lfsr_nx;
          round_cnt <= round_cnt + 1'b1;
          cnt       <= '0;
          fsm       <= DRAIN;
        end
        DRAIN: if (bus.out_ready) begin
          if (cnt == CW'(NBYTES-1)) begin
            cnt <= '0;
            fsm <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: fsm <= LOAD;
      endcase
      // Placed after the case so a restart during APPLY overrides the
      // LFSR/counter advance while the state still takes the old update.
      if (rc_restart) begin
        lfsr      <= RC_INIT;
        round_cnt <= '0;
      end
    end
  end

  assign bus.in_ready  = (fsm == LOAD);
  assign bus.out_valid = (fsm == DRAIN);
  assign bus.out_data  = (fsm == DRAIN) ? st_q[cnt*8 +: 8] : 8'h00;
  assign busy          = (fsm != LOAD) || (cnt != '0);

endmodule

// File: doc/gift64_perm_ark.md
Name: gift64_perm_ark

Overview:
- Downstream stage of the GIFT byte S-box ISE: consumes S-box output bytes and completes one GIFT-64 round.
- Completing a round means applying PermBits, then AddRoundKey (U/V) and the round constant.
- Accumulates 8 S-box output bytes into a 64-bit state, transforms it in one cycle, then returns 8 result bytes.
- Owns the 6-bit round-constant LFSR, so software only supplies round-key halves.

Parameters:
- NBYTES, 8, bytes per state (fixed for GIFT-64; exists only for loop bounds).
- RC_INIT, 6'h00, LFSR value loaded on reset / rc_restart.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rc_restart  in  1  pulse: reload LFSR with RC_INIT, clear round_cnt (start of new block)
- in_valid  in  1  S-box output byte valid
- in_ready  out  1  stage can accept a byte
- in_data  in  8  S-box output byte, byte 0 = state[7:0] first
- rk_u  in  16  round-key half U (xored into bits 4i+1)
- rk_v  in  16  round-key half V (xored into bits 4i)
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts byte
- out_data  out  8  result byte, byte 0 = state[7:0] first
- round_cnt  out  5  rounds completed since restart (wraps 31->0)
- busy  out  1  high in any state other than LOAD with byte count 0

Behaviour:
- Reset (async, rst_n=0): state register 0, byte count 0, FSM=LOAD, LFSR=RC_INIT, round_cnt=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0.
- FSM LOAD: in_ready=1.
  - On in_valid&in_ready: write in_data into state byte[cnt], cnt++.
  - On the 8th byte, latch rk_u/rk_v in the same cycle, go to APPLY. Bytes are never dropped.
- FSM APPLY (exactly 1 cycle, in_ready=0):
  - Permute: state'[P(i)] = s[i], where P(i) = 4*(i/16) + 16*((3*((i%16)/4) + (i%4)) % 4) + (i%4).
  - Key add: for i=0..15, state'[4i+1] ^= u[i] and state'[4i] ^= v[i].
  - Round constant: with LFSR c = c5..c0, update c = {c4,c3,c2,c1,c0,c5^c4^1} first, then XOR the new c into bits 23,19,15,11,7,3 (c5 onto bit 23 down to c0 onto bit 3); bit 63 ^= 1.
  - Round counter: round_cnt++. Go to DRAIN, cnt=0.
- FSM DRAIN: out_valid=1, out_data=state byte[cnt].
  - On out_ready: cnt++. After the 8th byte: out_valid=0, cnt=0, go to LOAD.
  - out_data is held stable while out_valid & !out_ready.
- Latency:
  - Last input byte accepted at cycle t; APPLY at t+1; first out_valid at t+2.
  - Minimum 17 cycles per round at full throughput.
- rc_restart:
  - Honoured in any state; synchronous.
  - Resets LFSR and round_cnt only. FSM and data are not affected.
  - If coincident with APPLY, restart wins: LFSR=RC_INIT, round_cnt=0, and the APPLY uses the pre-restart update.
- No simultaneous load and drain: in_ready=0 for the whole of APPLY and DRAIN.
- in_valid asserted while in_ready=0 is ignored; it is not an error.
- Reset asserted mid-operation aborts immediately; partial bytes are discarded.

Decomposition:
- Shared package gift_pkg holds:
  - GIFT64_RC_TAPS constant (bit positions 23,19,15,11,7,3).
  - RC_WIDTH=6.
  - The P64 index function.
  - FSM state typedef {LOAD, APPLY, DRAIN}.
- One natural sub-module: gift64_permbits, purely combinational, 64 in / 64 out, generated from the P(i) function.
  - Reused later by the key-schedule and decrypt ISEs.

Test Plan:
- Zero state, rk_u=rk_v=0, first round after reset: send 8x 00 -> out bytes 08,00,00,00,00,00,00,80 (state 0x8000000000000008), round_cnt=1.
- Second consecutive round, zero input and zero key: LFSR=0x03 -> out bytes 88,00,00,00,00,00,00,80.
- Permutation check after rc_restart: input bytes 02,00,00,00,00,00,00,00, key 0.
  - Bit 1 maps to bit 17 -> out bytes 08,00,02,00,00,00,00,80.
- Key add: zero input, rk_u=16'h0001, rk_v=16'h0001, first round -> out bytes 0B,00,00,00,00,00,00,80.
- Backpressure: hold out_ready=0 for 5 cycles after first out_valid.
  - out_data must stay 08 and in_ready must stay 0.
  - Release -> all 8 bytes in order.
- Async reset after 4 of 8 input bytes: outputs return to reset values immediately.
  - A subsequent full 8-byte zero block yields 08,..,80 with round_cnt=1.
